// File: rtl/mine_gen_ctrl_if.sv
// Board mine RAM port: a single write/read port with 1-cycle read latency.
// master = generation controller, slave = RAM.
interface mine_gen_ctrl_if;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic       mem_wdata;
  logic       mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mine_gen_ctrl.sv
// Board generation sequencer: clears the mine RAM, then places distinct LFSR-drawn mines.
// Optional macro SAFE_ZONE_EN widens the first-click exclusion to its 3x3 neighbourhood.
module mine_gen_ctrl #(
  parameter int LFSR_W    = 16,
  parameter int CLR_CELLS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            dimension_size,
  input  logic [5:0]            mines,
  input  logic [15:0]           seed,
  input  logic [3:0]            safe_x,
  input  logic [3:0]            safe_y,
  mine_gen_ctrl_if.master       mem,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [5:0]            placed
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_DRAW   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT = LFSR_W'(16'hACE1);
  localparam logic [7:0]        CLR_LAST     = 8'(CLR_CELLS - 1);

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    lfsr_step = {fb, v[LFSR_W-1:1]};
  endfunction

  function automatic logic [5:0] clamp_target(input logic [4:0] dim, input logic [5:0] req);
    logic [8:0] area;
    logic [8:0] limit;
    area = {4'd0, dim} * {4'd0, dim};
`ifdef SAFE_ZONE_EN
    limit = (area > 9'd9) ? (area - 9'd9) : 9'd0;
`else
    limit = (area > 9'd0) ? (area - 9'd1) : 9'd0;
`endif
    clamp_target = ({3'd0, req} < limit) ? req : limit[5:0];
  endfunction

  function automatic logic excluded(input logic [3:0] x, input logic [3:0] y,
                                    input logic [3:0] sx, input logic [3:0] sy);
`ifdef SAFE_ZONE_EN
    logic [4:0] xe, ye, sxe, sye;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    sxe = {1'b0, sx};
    sye = {1'b0, sy};
    // Widened compares keep the neighbourhood clipped at the board edges without wrap.
    excluded = (xe + 5'd1 >= sxe) && (xe <= sxe + 5'd1) &&
               (ye + 5'd1 >= sye) && (ye <= sye + 5'd1);
`else
    excluded = (x == sx) && (y == sy);
`endif
  endfunction

  state_t            state_r, state_s;
  logic [4:0]        dim_r, dim_s;
  logic [5:0]        target_r, target_s;
  logic [3:0]        sx_r, sx_s;
  logic [3:0]        sy_r, sy_s;
  logic [LFSR_W-1:0] lfsr_r, lfsr_s;
  logic              we_r, we_s;
  logic [7:0]        addr_r, addr_s;
  logic              wdata_r, wdata_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic [5:0]        placed_r, placed_s;

  logic              start_ok_s;
  logic [3:0]        cand_x_s;
  logic [3:0]        cand_y_s;
  logic              cand_ok_s;

  assign start_ok_s = (dimension_size != 5'd0) && (dimension_size <= 5'd16) &&
                      ({1'b0, safe_x} < dimension_size) &&
                      ({1'b0, safe_y} < dimension_size);

  assign cand_x_s  = lfsr_r[3:0];
  assign cand_y_s  = lfsr_r[7:4];
  assign cand_ok_s = ({1'b0, cand_x_s} < dim_r) && ({1'b0, cand_y_s} < dim_r) &&
                     !excluded(cand_x_s, cand_y_s, sx_r, sy_r);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s  = state_r;
    dim_s    = dim_r;
    target_s = target_r;
    sx_s     = sx_r;
    sy_s     = sy_r;
    lfsr_s   = lfsr_r;
    we_s     = 1'b0;
    addr_s   = addr_r;
    wdata_s  = 1'b0;
    busy_s   = busy_r;
    done_s   = 1'b0;
    error_s  = 1'b0;
    placed_s = placed_r;

    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          if (start_ok_s) begin
            dim_s    = dimension_size;
            target_s = clamp_target(dimension_size, mines);
            sx_s     = safe_x;
            sy_s     = safe_y;
            lfsr_s   = (seed == 16'd0) ? LFSR_DEFAULT : LFSR_W'(seed);
            placed_s = 6'd0;
            busy_s   = 1'b1;
            we_s     = 1'b1;
            addr_s   = 8'd0;
            state_s  = ST_CLEAR;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (addr_r == CLR_LAST) begin
          if (target_r == 6'd0) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FINISH;
          end else begin
            state_s = ST_DRAW;
          end
        end else begin
          we_s   = 1'b1;
          addr_s = addr_r + 8'd1;
        end
      end

      ST_DRAW: begin
        lfsr_s = lfsr_step(lfsr_r);
        if (cand_ok_s) begin
          addr_s  = {cand_y_s, cand_x_s};
          state_s = ST_WAIT;
        end else begin
          state_s = ST_DRAW;
        end
      end

      ST_WAIT: begin
        state_s = ST_CHECK;
      end

      // The write is registered, so it lands in the cycle after CHECK at the same address.
      ST_CHECK: begin
        if (mem.mem_rdata) begin
          state_s = ST_DRAW;
        end else begin
          we_s     = 1'b1;
          wdata_s  = 1'b1;
          placed_s = placed_r + 6'd1;
          if ((placed_r + 6'd1) == target_r) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FINISH;
          end else begin
            state_s = ST_DRAW;
          end
        end
      end

      ST_FINISH: begin
        state_s = ST_IDLE;
      end

      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      dim_r    <= 5'd0;
      target_r <= 6'd0;
      sx_r     <= 4'd0;
      sy_r     <= 4'd0;
      lfsr_r   <= LFSR_DEFAULT;
      we_r     <= 1'b0;
      addr_r   <= 8'd0;
      wdata_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      placed_r <= 6'd0;
    end else begin
      state_r  <= state_s;
      dim_r    <= dim_s;
      target_r <= target_s;
      sx_r     <= sx_s;
      sy_r     <= sy_s;
      lfsr_r   <= lfsr_s;
      we_r     <= we_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      error_r  <= error_s;
      placed_r <= placed_s;
    end
  end

  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign placed        = placed_r;

endmodule

// File: tb/tb_mine_gen_ctrl.sv
// Directed bench for mine_gen_ctrl: RAM model, write monitor, and a queue of expected outcomes.
module tb_mine_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  dimension_size;
  logic [5:0]  mines;
  logic [15:0] seed;
  logic [3:0]  safe_x;
  logic [3:0]  safe_y;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  placed;

  mine_gen_ctrl_if mem_bus ();

  mine_gen_ctrl #(.LFSR_W(16), .CLR_CELLS(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dimension_size (dimension_size),
    .mines          (mines),
    .seed           (seed),
    .safe_x         (safe_x),
    .safe_y         (safe_y),
    .mem            (mem_bus.master),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .placed         (placed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int target;
    bit err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] seed0_q[$];
  logic       ram [0:255];

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt, mine_cnt, bad_cnt, done_cnt, err_cnt, we_cnt;
  int cur_dim, cur_sx, cur_sy;
  int mx, my;

  function automatic bit excluded(int x, int y, int sx, int sy);
`ifdef SAFE_ZONE_EN
    return (x - sx <= 1) && (sx - x <= 1) && (y - sy <= 1) && (sy - y <= 1);
`else
    return (x == sx) && (y == sy);
`endif
  endfunction

  function automatic int exp_target(int d, int m);
    int lim;
`ifdef SAFE_ZONE_EN
    lim = (d * d > 9) ? d * d - 9 : 0;
`else
    lim = d * d - 1;
`endif
    return (m < lim) ? m : lim;
  endfunction

  // Single-port RAM, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_bus.mem_we === 1'b1) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  // Write monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_bus.mem_we === 1'b1) begin
      we_cnt++;
      if (mem_bus.mem_wdata === 1'b0) begin
        if (mem_bus.mem_addr != 8'(clr_cnt) || mine_cnt != 0) bad_cnt++;
        clr_cnt++;
      end else begin
        mine_cnt++;
        wr_q.push_back(mem_bus.mem_addr);
        mx = int'(mem_bus.mem_addr[3:0]);
        my = int'(mem_bus.mem_addr[7:4]);
        if (mx >= cur_dim || my >= cur_dim || excluded(mx, my, cur_sx, cur_sy)) bad_cnt++;
        if (ram[mem_bus.mem_addr] === 1'b1) bad_cnt++;
      end
    end
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input int d, input int m, input int s, input int sx, input int sy);
    exp_t e;
    @(negedge clk);
    clr_cnt = 0; mine_cnt = 0; bad_cnt = 0; done_cnt = 0; err_cnt = 0; we_cnt = 0;
    wr_q.delete();
    cur_dim = d; cur_sx = sx; cur_sy = sy;
    e.err    = (d == 0) || (d > 16) || (sx >= d) || (sy >= d);
    e.target = e.err ? 0 : exp_target(d, m);
    exp_q.push_back(e);
    dimension_size = 5'(d);
    mines          = 6'(m);
    seed           = 16'(s);
    safe_x         = 4'(sx);
    safe_y         = 4'(sy);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_gen(input string tag, input int poke_at);
    exp_t e;
    int   cycles;
    int   busy_drop;
    int   ones;
    e = exp_q.pop_front();
    if (e.err) begin
      check({tag, "_err_pulse"}, 32'(error), 32'd1);
      check({tag, "_err_busy"}, 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check({tag, "_err_once"}, 32'(err_cnt), 32'd1);
      check({tag, "_err_no_we"}, 32'(we_cnt), 32'd0);
      check({tag, "_err_idle"}, 32'(busy), 32'd0);
    end else begin
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      check({tag, "_placed_cleared"}, 32'(placed), 32'd0);
      cycles = 0;
      busy_drop = 0;
      while (done !== 1'b1 && cycles < 20000) begin
        if (busy !== 1'b1) busy_drop++;
        if (cycles == poke_at) begin
          start = 1'b1; dimension_size = 5'd4; mines = 6'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cycles++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_placed"}, 32'(placed), 32'(e.target));
      check({tag, "_clear_writes"}, 32'(clr_cnt), 32'd256);
      check({tag, "_mine_writes"}, 32'(mine_cnt), 32'(e.target));
      check({tag, "_bad_writes"}, 32'(bad_cnt), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      check({tag, "_placed_hold"}, 32'(placed), 32'(e.target));
      ones = 0;
      for (int a = 0; a < 256; a++) if (ram[a] === 1'b1) ones++;
      check({tag, "_ram_mines"}, 32'(ones), 32'(e.target));
    end
  endtask

  task automatic compare_seq(input string tag, input logic [7:0] r[$]);
    int diffs;
    diffs = 0;
    check({tag, "_len"}, 32'(wr_q.size()), 32'(r.size()));
    for (int i = 0; i < wr_q.size() && i < r.size(); i++) if (wr_q[i] !== r[i]) diffs++;
    check({tag, "_seq"}, 32'(diffs), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dimension_size = 5'd0; mines = 6'd0;
    seed = 16'd0; safe_x = 4'd0; safe_y = 4'd0;
    cur_dim = 0; cur_sx = 0; cur_sy = 0;
    clr_cnt = 0; mine_cnt = 0; bad_cnt = 0; done_cnt = 0; err_cnt = 0; we_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_placed", 32'(placed), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    kick(8, 10, 16'h1234, 0, 0);
    finish_gen("d8m10", -1);
    ref_q = wr_q;

    kick(8, 10, 16'h1234, 0, 0);
    finish_gen("d8m10_rep", -1);
    compare_seq("determinism", ref_q);

    kick(16, 63, 0, 5, 7);
    finish_gen("d16_seed0", -1);
    seed0_q = wr_q;
    kick(16, 63, 16'hACE1, 5, 7);
    finish_gen("d16_ace1", -1);
    compare_seq("seed0_is_ace1", seed0_q);

    kick(0, 5, 16'h0042, 0, 0);
    finish_gen("dim0", -1);
    kick(17, 5, 16'h0042, 0, 0);
    finish_gen("dim17", -1);
    kick(4, 5, 16'h0042, 4, 0);
    finish_gen("safe_out", -1);

    kick(8, 63, 16'hBEEF, 4, 4);
    finish_gen("d8_full", -1);

    kick(1, 5, 16'h0007, 0, 0);
    finish_gen("d1_zero", -1);

    kick(8, 10, 16'h1234, 0, 0);
    finish_gen("poke", 270);
    compare_seq("poke_ignored", ref_q);

    kick(8, 10, 16'h1234, 0, 0);
    void'(exp_q.pop_front());
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we", 32'(mem_bus.mem_we), 32'd0);
    check("midrst_placed", 32'(placed), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    kick(8, 10, 16'h1234, 0, 0);
    finish_gen("after_rst", -1);
    compare_seq("after_rst", ref_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
